trb_mem_arbiter: RTL

Arbiter and sequencer for the single-port trace-buffer memory. The memory is shared between two requesters: the trace logger (trace stores and streaming reads) and the debug system interface (host readout and preload). The block grants at most one access per two cycles as a one-cycle turn strobe and drives the memory. It returns read data with a valid pulse and provides strict-priority-with-anti-starvation or round-robin scheduling. It instantiates the RAM and sits between the logger, the interface and storage.

---
 rtl/dtb_pkg.sv | 18 +
 rtl/trb_spram.sv | 49 ++++
 rtl/trb_mem_arbiter.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/dtb_pkg.sv
// Shared definitions for the trace-buffer memory arbiter: default geometry,
// arbiter FSM states and requester identifiers.
package dtb_pkg;

  localparam int unsigned TRB_WIDTH = 64;
  localparam int unsigned TRB_DEPTH = 256;

  typedef enum logic {
    ST_ARB    = 1'b0,
    ST_ACCESS = 1'b1
  } arb_state_t;

  typedef enum logic {
    REQ_LOG = 1'b0,
    REQ_IF  = 1'b1
  } req_id_t;

endpackage

// File: rtl/trb_spram.sv
// Synchronous single-port RAM, DEPTH x WIDTH, one-cycle read latency.
// The array itself is not reset; only the read-data register is, so the
// read port shows zero until the first read after reset.
// Ports: clk_i/rst_ni clock and async active-low reset; en_i access enable;
// we_i write enable; addr_i word address; wdata_i write data; rdata_o read
// data (updated only by reads, holds otherwise).
module trb_spram #(
  parameter  int unsigned WIDTH = 64,
  parameter  int unsigned DEPTH = 256,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             we_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_d, rdata_q;

  // Storage array, written only on an enabled write.
  always_ff @(posedge clk_i) begin
    if (en_i && we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  // Read register keeps the last read value between reads.
  always_comb begin
    rdata_d = rdata_q;
    if (en_i && !we_i) begin
      rdata_d = mem_q[addr_i];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/trb_mem_arbiter.sv
// Arbiter/sequencer for the single-port trace-buffer RAM shared by the trace
// logger (log_*) and the debug interface (if_*). At most one access every two
// cycles: a request seen in ST_ARB is latched, performed in ST_ACCESS with a
// one-cycle turn strobe, and read data returns the following cycle.
// Ports: clk_i/rst_ni clock and async active-low reset; log_first_i selects
// logger priority (1) or round-robin (0); per requester req/we/ptr/wdata in
// and turn out; rdata_o shared read data; log_rvalid_o/if_rvalid_o read-data
// valid per requester; starved_o sticky flag for a forced interface grant.
module trb_mem_arbiter #(
  parameter  int unsigned TRB_WIDTH    = dtb_pkg::TRB_WIDTH,
  parameter  int unsigned TRB_DEPTH    = dtb_pkg::TRB_DEPTH,
  parameter  int unsigned STARVE_LIMIT = 15,
  localparam int unsigned AW           = $clog2(TRB_DEPTH)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 log_first_i,
  input  logic                 log_req_i,
  input  logic                 log_we_i,
  input  logic [AW-1:0]        log_ptr_i,
  input  logic [TRB_WIDTH-1:0] log_wdata_i,
  output logic                 log_turn_o,
  input  logic                 if_req_i,
  input  logic                 if_we_i,
  input  logic [AW-1:0]        if_ptr_i,
  input  logic [TRB_WIDTH-1:0] if_wdata_i,
  output logic                 if_turn_o,
  output logic [TRB_WIDTH-1:0] rdata_o,
  output logic                 log_rvalid_o,
  output logic                 if_rvalid_o,
  output logic                 starved_o
);

  import dtb_pkg::*;

  localparam int unsigned WAIT_W = 8;

  arb_state_t           state_d, state_q;
  req_id_t              winner_d, winner_q;
  req_id_t              last_d, last_q;
  req_id_t              win;
  logic                 we_d, we_q;
  logic [AW-1:0]        ptr_d, ptr_q;
  logic [TRB_WIDTH-1:0] wdata_d, wdata_q;
  logic                 log_turn_d, log_turn_q;
  logic                 if_turn_d, if_turn_q;
  logic                 log_rvalid_d, log_rvalid_q;
  logic                 if_rvalid_d, if_rvalid_q;
  logic                 starved_d, starved_q;
  logic [WAIT_W-1:0]    wait_cnt_d, wait_cnt_q;
  logic                 if_grant;
  logic                 ram_en;

  // Next-state, command capture and strobe generation.
  always_comb begin
    state_d      = state_q;
    winner_d     = winner_q;
    last_d       = last_q;
    we_d         = we_q;
    ptr_d        = ptr_q;
    wdata_d      = wdata_q;
    log_turn_d   = 1'b0;
    if_turn_d    = 1'b0;
    log_rvalid_d = 1'b0;
    if_rvalid_d  = 1'b0;
    starved_d    = starved_q;
    if_grant     = 1'b0;
    win          = REQ_LOG;

    unique case (state_q)
      ST_ARB: begin
        if (log_req_i || if_req_i) begin
          if (log_req_i && if_req_i) begin
            if (log_first_i) begin
              // Logger priority, unless the interface has waited too long.
              if (wait_cnt_q >= WAIT_W'(STARVE_LIMIT)) begin
                win       = REQ_IF;
                starved_d = 1'b1;
              end else begin
                win = REQ_LOG;
              end
            end else begin
              win = (last_q == REQ_IF) ? REQ_LOG : REQ_IF;
            end
          end else begin
            win = if_req_i ? REQ_IF : REQ_LOG;
          end
          winner_d   = win;
          last_d     = win;
          we_d       = (win == REQ_IF) ? if_we_i    : log_we_i;
          ptr_d      = (win == REQ_IF) ? if_ptr_i   : log_ptr_i;
          wdata_d    = (win == REQ_IF) ? if_wdata_i : log_wdata_i;
          log_turn_d = (win == REQ_LOG);
          if_turn_d  = (win == REQ_IF);
          if_grant   = (win == REQ_IF);
          state_d    = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        log_rvalid_d = !we_q && (winner_q == REQ_LOG);
        if_rvalid_d  = !we_q && (winner_q == REQ_IF);
        if_grant     = (winner_q == REQ_IF);
        state_d      = ST_ARB;
      end
    endcase
  end

  // Interface wait counter: saturating, cleared when idle or being served.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!if_req_i || if_grant) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != '1) begin
      wait_cnt_d = wait_cnt_q + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_ARB;
      winner_q     <= REQ_LOG;
      last_q       <= REQ_IF;
      we_q         <= 1'b0;
      ptr_q        <= '0;
      wdata_q      <= '0;
      log_turn_q   <= 1'b0;
      if_turn_q    <= 1'b0;
      log_rvalid_q <= 1'b0;
      if_rvalid_q  <= 1'b0;
      starved_q    <= 1'b0;
      wait_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      winner_q     <= winner_d;
      last_q       <= last_d;
      we_q         <= we_d;
      ptr_q        <= ptr_d;
      wdata_q      <= wdata_d;
      log_turn_q   <= log_turn_d;
      if_turn_q    <= if_turn_d;
      log_rvalid_q <= log_rvalid_d;
      if_rvalid_q  <= if_rvalid_d;
      starved_q    <= starved_d;
      wait_cnt_q   <= wait_cnt_d;
    end
  end

  // RAM enable follows the state flop so reset removes it at once.
  assign ram_en = (state_q == ST_ACCESS);

  trb_spram #(
    .WIDTH (TRB_WIDTH),
    .DEPTH (TRB_DEPTH)
  ) u_spram (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .en_i    (ram_en),
    .we_i    (we_q),
    .addr_i  (ptr_q),
    .wdata_i (wdata_q),
    .rdata_o (rdata_o)
  );

  assign log_turn_o   = log_turn_q;
  assign if_turn_o    = if_turn_q;
  assign log_rvalid_o = log_rvalid_q;
  assign if_rvalid_o  = if_rvalid_q;
  assign starved_o    = starved_q;

endmodule
